ifmp1_slave_resp: RTL and testbench



---
 rtl/ifmp1_pkg.sv | 34 +++
 rtl/ifmp1_if.sv | 11 +
 rtl/ifmp1_slave_fifo.sv | 75 +++++++
 rtl/ifmp1_slave_resp.sv | 99 +++++++++
 tb/tb_ifmp1_slave_resp.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/ifmp1_pkg.sv
// Shared field positions, payload types and state encoding for the ifmp1 responder.
// Imported by the bus interface, the buffer and the responder top.
package ifmp1_pkg;

    localparam int WORD_W    = 32;
    localparam int VALID_BIT = 31;
    localparam int LAST_BIT  = 30;
    localparam int DATA_MSB  = 29;
    localparam int DATA_LSB  = 0;
    localparam int DATA_W    = 30;
    localparam int PAYLOAD_W = 31;

    typedef logic [DATA_W-1:0] ifmp1_data_t;

    // Buffered word: end-of-frame flag above the data bits, matching m_data
    typedef struct packed {
        logic        last;
        ifmp1_data_t data;
    } ifmp1_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } resp_state_t;

    function automatic ifmp1_payload_t ifmp1_unpack(input logic [WORD_W-1:0] word);
        ifmp1_payload_t p;
        p.last = word[LAST_BIT];
        p.data = word[DATA_MSB:DATA_LSB];
        return p;
    endfunction

endpackage

// File: rtl/ifmp1_if.sv
// ifmp1 link: sig1 carries {valid, last, data} from master, sig2 is the responder's ready.
interface ifmp1;
    import ifmp1_pkg::*;

    logic [WORD_W-1:0] sig1;
    logic              sig2;

    modport master (output sig1, input sig2);
    modport slave  (input sig1, output sig2);

endinterface

// File: rtl/ifmp1_slave_fifo.sv
// First-word-fall-through buffer for the responder: storage, wrapping pointers, occupancy.
// Storage is deliberately left out of reset; only pointers and occupancy clear.
module ifmp1_slave_fifo
    import ifmp1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  ifmp1_payload_t         din,
    input  logic                   pop,
    output ifmp1_payload_t         dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   not_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    ifmp1_payload_t mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [LW-1:0]  level_r;
    logic           not_empty_r;

    logic           wr_en_s;
    logic           rd_en_s;
    logic [LW-1:0]  level_nxt_s;

    // Qualify push/pop against full/empty and compute the next occupancy
    always_comb begin
        wr_en_s     = push && ((level_r != LW'(DEPTH)) || pop);
        rd_en_s     = pop && not_empty_r;
        level_nxt_s = level_r;
        if (wr_en_s && !rd_en_s) begin
            level_nxt_s = level_r + LW'(1'b1);
        end else if (!wr_en_s && rd_en_s) begin
            level_nxt_s = level_r - LW'(1'b1);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            level_r     <= {LW{1'b0}};
            not_empty_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            level_r     <= level_nxt_s;
            not_empty_r <= (level_nxt_s != {LW{1'b0}});
        end
    end

    // Word storage
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout      = mem_r[rd_ptr_r];
    assign level     = level_r;
    assign not_empty = not_empty_r;

endmodule

// File: rtl/ifmp1_slave_resp.sv
// ifmp1 responder: accepts master words into a FWFT buffer, drives registered ready (sig2)
// and counts completed frames. sig2 depends only on flops, never on sig1.
module ifmp1_slave_resp
    import ifmp1_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    ifmp1.slave                    bus,
    output logic [PAYLOAD_W-1:0]   m_data,
    output logic                   m_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       frm_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;

    resp_state_t    state_r;
    logic           sig2_r;
    logic [CNT_W-1:0] frm_cnt_r;

    ifmp1_payload_t in_word_s;
    ifmp1_payload_t out_word_s;
    logic           push_s;
    logic           pop_s;
    logic [LW-1:0]  level_s;
    logic [LW-1:0]  level_nxt_s;
    logic           not_empty_s;

    // Transfer qualification and the occupancy the buffer will hold after this edge
    always_comb begin
        in_word_s   = ifmp1_unpack(bus.sig1);
        push_s      = bus.sig1[VALID_BIT] && sig2_r;
        pop_s       = not_empty_s && m_ready;
        level_nxt_s = level_s + LW'(push_s) - LW'(pop_s);
    end

    ifmp1_slave_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .din       (in_word_s),
        .pop       (pop_s),
        .dout      (out_word_s),
        .level     (level_s),
        .not_empty (not_empty_s)
    );

    // Occupancy state machine, ready flop and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_EMPTY;
            sig2_r    <= 1'b0;
            frm_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_r <= ST_PARTIAL;
                    end
                end
                ST_PARTIAL: begin
                    if (level_nxt_s == LW'(DEPTH)) begin
                        state_r <= ST_FULL;
                    end else if (level_nxt_s == {LW{1'b0}}) begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop_s && !push_s) begin
                        state_r <= ST_PARTIAL;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
            // Ready drops the cycle after the buffer fills, so an offered word is never lost
            sig2_r <= (level_nxt_s < LW'(DEPTH));
            if (push_s && in_word_s.last) begin
                frm_cnt_r <= frm_cnt_r + CNT_W'(1'b1);
            end
        end
    end

    assign bus.sig2 = sig2_r;
    assign m_data   = out_word_s;
    assign m_last   = out_word_s.last;
    assign m_valid  = not_empty_s;
    assign level    = level_s;
    assign frm_cnt  = frm_cnt_r;

endmodule

// File: tb/tb_ifmp1_slave_resp.sv
// Directed and randomized bench for ifmp1_slave_resp against a queue-based reference model.
module tb_ifmp1_slave_resp;
    import ifmp1_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifmp1 bus();
    logic [30:0]      m_data;
    logic             m_last;
    logic             m_valid;
    logic             m_ready;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] frm_cnt;

    ifmp1_slave_resp #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .level   (level),
        .frm_cnt (frm_cnt)
    );

    // Reference model: contents of the buffer in order, expected ready, frame total
    logic [30:0] q[$];
    logic        exp_sig2;
    int          exp_frm;
    logic        last_push;
    int          checks;
    int          fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".level"},   32'(level),   32'(q.size()));
        chk({ph, ".m_valid"}, 32'(m_valid), 32'(q.size() != 0));
        chk({ph, ".sig2"},    32'(bus.sig2), 32'(exp_sig2));
        chk({ph, ".frm_cnt"}, 32'(frm_cnt), 32'(exp_frm % (1 << CNT_W)));
        if (q.size() != 0) begin
            chk({ph, ".m_data"}, 32'(m_data), 32'(q[0]));
            chk({ph, ".m_last"}, 32'(m_last), 32'(q[0][30]));
        end
    endtask

    // One clock: decide transfers from the model, advance the model, then compare
    task automatic step(input string ph);
        logic [31:0] w;
        logic        push;
        logic        pop;
        w    = bus.sig1;
        push = w[31] && exp_sig2;
        pop  = (q.size() != 0) && m_ready;
        @(posedge clk);
        if (pop) q.delete(0);
        if (push) begin
            q.push_back(w[30:0]);
            if (w[30]) exp_frm++;
        end
        exp_sig2  = (q.size() < DEPTH);
        last_push = push;
        #1;
        check_all(ph);
    endtask

    function automatic logic [31:0] word(input logic v, input logic l, input int d);
        return {v, l, 30'(d)};
    endfunction

    initial begin
        checks    = 0;
        fails     = 0;
        exp_sig2  = 1'b0;
        exp_frm   = 0;
        last_push = 1'b0;
        bus.sig1  = 32'h0;
        m_ready   = 1'b0;

        // Asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #2 check_all("reset");
        #9 rst = 1'b0;
        step("idle0");
        step("idle1");

        // Short frame streamed with the consumer always ready
        m_ready = 1'b1;
        bus.sig1 = word(1'b1, 1'b0, 1); step("s1");
        bus.sig1 = word(1'b1, 1'b0, 2); step("s2");
        bus.sig1 = word(1'b1, 1'b1, 3); step("s3");
        bus.sig1 = 32'h0;               step("s4");
        step("s5");
        chk("stream.frm_cnt", 32'(frm_cnt), 32'd1);

        // Fill with consumer stalled; fifth word must be held until a slot frees
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.sig1 = word(1'b1, 1'b0, 32'h100 + i);
            step("fill");
        end
        bus.sig1 = word(1'b1, 1'b1, 32'h105);
        step("stall0");
        step("stall1");
        m_ready = 1'b1;
        step("free");
        m_ready = 1'b0;
        step("take5");
        chk("stall.level_full", 32'(level), 32'(DEPTH));

        // Full buffer with the master still offering and the consumer draining
        bus.sig1 = word(1'b1, 1'b0, 32'h200);
        m_ready = 1'b1;
        step("fp0");
        bus.sig1 = word(1'b1, 1'b1, 32'h201);
        step("fp1");
        bus.sig1 = 32'h0;
        for (int i = 0; i < DEPTH + 1; i++) step("drain");

        // Random traffic: exercises pointer wrap, stalls and frame-counter wrap
        for (int i = 0; i < 200; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (last_push || !bus.sig1[31]) begin
                bus.sig1 = {($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 30'($urandom)};
            end
            step("rand");
        end
        chk("rand.frm_progress", 32'(exp_frm > 16), 32'd1);

        // Drain, leave three words of an open frame, then reset between edges
        bus.sig1 = 32'h0;
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step("pre_rst");
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.sig1 = word(1'b1, 1'b0, 32'h300 + i);
            step("part");
        end
        bus.sig1 = 32'h0;
        chk("part.level3", 32'(level), 32'd3);
        #2 rst = 1'b1;
        q.delete();
        exp_sig2 = 1'b0;
        exp_frm  = 0;
        #1 check_all("mid_rst");
        #4 rst = 1'b0;

        // Stream resumes after reset
        bus.sig1 = word(1'b1, 1'b1, 32'h3AA);
        step("res0");
        step("res1");
        bus.sig1 = 32'h0;
        m_ready = 1'b1;
        step("res2");
        step("res3");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
